// File: rtl/convert_arb_64.sv
// convert_arb_64: round-robin arbiter sharing one word channel among N requesters
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   i_data      N packed requester words, requester k at [k*DW +: DW]
//   i_rval      per-requester valid
//   o_rrdy      per-requester ready, at most one bit high
//   o_data      registered word toward the serializer
//   o_src       requester index that supplied o_data
//   o_tval      o_data/o_src valid
//   i_trdy      serializer ready
//   i_cnt_clr   clears the word counters (CONV_ARB_STATS_EN builds only)
//   o_word_cnt  saturating per-requester accepted-word counters, 16 bits each
// Define CONV_ARB_STATS_EN to build the counters; otherwise o_word_cnt is 0.
module convert_arb_64 #(
   parameter int N = 4,
   parameter int DW = 64,
   parameter int MAX_BURST = 4,
   parameter int SW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N*DW-1:0] i_data,
   input  logic [N-1:0]    i_rval,
   output logic [N-1:0]    o_rrdy,
   output logic [DW-1:0]   o_data,
   output logic [SW-1:0]   o_src,
   output logic            o_tval,
   input  logic            i_trdy,
   input  logic            i_cnt_clr,
   output logic [N*16-1:0] o_word_cnt
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nxt;
   logic [SW-1:0] owner, rr_ptr, pick;
   logic [3:0] burst_cnt;
   logic [N-1:0] rot;
   logic [DW-1:0] word;
   logic any_val, own_val, out_rdy, in_xfer, rel;
   assign out_rdy = ~o_tval | i_trdy;
   assign own_val = |(i_rval & (N'(1) << owner));
   assign word = DW'(i_data >> (int'(owner) * DW));
   // Rotate valids so bit 0 is rr_ptr; scanning downward lets the nearest set bit win.
   always_comb begin
      rot = N'({i_rval, i_rval} >> rr_ptr);
      pick = '0;
      any_val = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            pick = SW'((int'(rr_ptr) + j) >= N ? int'(rr_ptr) + j - N : int'(rr_ptr) + j);
            any_val = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   // Release fires on the transfer that completes the burst or on any cycle the owner is not valid.
   always_comb begin
      state_nxt = state;
      o_rrdy = '0;
      in_xfer = 1'b0;
      rel = 1'b0;
      if (state == IDLE) begin
         state_nxt = any_val ? GRANT : IDLE;
      end else begin
         o_rrdy = out_rdy ? N'(1) << owner : '0;
         in_xfer = own_val & out_rdy;
         rel = ~own_val | (in_xfer && burst_cnt == 4'(MAX_BURST - 1));
         state_nxt = rel ? IDLE : GRANT;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         owner <= '0;
         rr_ptr <= '0;
         burst_cnt <= '0;
         o_tval <= 1'b0;
         o_data <= '0;
         o_src <= '0;
      end else begin
         if (state == IDLE && any_val) begin
            owner <= pick;
            burst_cnt <= '0;
         end
         if (in_xfer) burst_cnt <= burst_cnt + 1'b1;
         if (rel) rr_ptr <= owner == SW'(N - 1) ? '0 : owner + 1'b1;
         if (in_xfer) begin
            o_data <= word;
            o_src <= owner;
            o_tval <= 1'b1;
         end else if (o_tval & i_trdy) begin
            o_tval <= 1'b0;
         end
      end
`ifdef CONV_ARB_STATS_EN
   for (genvar k = 0; k < N; k++) begin : g_cnt
      logic [15:0] cnt;
      always_ff @(posedge clk or posedge reset)
         if (reset) cnt <= '0;
         else if (i_cnt_clr) cnt <= '0;
         else if (in_xfer && owner == SW'(k) && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
      assign o_word_cnt[k*16 +: 16] = cnt;
   end
`else
   logic unused_clr;
   assign unused_clr = i_cnt_clr;
   assign o_word_cnt = '0;
`endif
endmodule

// File: tb/tb_convert_arb_64.sv
// tb_convert_arb_64: directed self-checking bench for convert_arb_64
module tb_convert_arb_64;
   logic clk = 1'b0;
   logic reset;
   logic [255:0] i_data;
   logic [3:0] i_rval;
   logic [3:0] o_rrdy;
   logic [63:0] o_data;
   logic [2:0] o_src;
   logic o_tval;
   logic i_trdy;
   logic i_cnt_clr;
   logic [63:0] o_word_cnt;

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   int total [4];
   int in_idx [4];
   int out_next [8];
   int out_src [$];
   int out_cyc [$];
   int in_cyc [$];
   logic [3:0] rr_log [int];
   logic hold;
   logic [63:0] hold_data;
   logic [2:0] hold_src;

   always #5 clk = ~clk;

   convert_arb_64 dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_rval(i_rval), .o_rrdy(o_rrdy),
      .o_data(o_data), .o_src(o_src), .o_tval(o_tval), .i_trdy(i_trdy),
      .i_cnt_clr(i_cnt_clr), .o_word_cnt(o_word_cnt)
   );

   function automatic logic [63:0] word(int k, int i);
      return {8'hA5, 8'(k), 16'h0, 32'(i)};
   endfunction

   task automatic drive(int k);
      i_rval[k] = in_idx[k] < total[k];
      i_data[k*64 +: 64] = word(k, in_idx[k]);
   endtask

   task automatic load(int k, int n);
      total[k] = n;
      in_idx[k] = 0;
      drive(k);
   endtask

   task automatic clear_sb();
      for (int k = 0; k < 4; k++) begin
         total[k] = 0;
         in_idx[k] = 0;
      end
      for (int k = 0; k < 8; k++) out_next[k] = 0;
      out_src.delete();
      out_cyc.delete();
      in_cyc.delete();
      hold = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_rval = '0;
      i_data = '0;
      i_cnt_clr = 1'b0;
      i_trdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_sb();
   endtask

   // One clock: observe at the falling edge, advance requester words after the rising edge.
   task automatic cycle();
      int xk;
      xk = -1;
      @(negedge clk);
      rr_log[cyc] = o_rrdy;
      vectors++;
      if ($countones(o_rrdy) > 1) begin
         errors++;
         $display("FAIL onehot cyc %0d: o_rrdy=%b required at most one bit", cyc, o_rrdy);
      end
      for (int k = 0; k < 4; k++)
         if (i_rval[k] && o_rrdy[k]) begin
            xk = k;
            in_cyc.push_back(cyc);
         end
      if (hold) begin
         vectors++;
         if (o_data !== hold_data || o_src !== hold_src) begin
            errors++;
            $display("FAIL stable cyc %0d: o_data=%h o_src=%0d required %h %0d", cyc, o_data, o_src, hold_data, hold_src);
         end
      end
      if (o_tval && i_trdy) begin
         out_src.push_back(int'(o_src));
         out_cyc.push_back(cyc);
         vectors++;
         if (o_data !== word(int'(o_src), out_next[o_src])) begin
            errors++;
            $display("FAIL order cyc %0d: o_data=%h required %h", cyc, o_data, word(int'(o_src), out_next[o_src]));
         end
         out_next[o_src]++;
      end
      hold = o_tval && !i_trdy;
      hold_data = o_data;
      hold_src = o_src;
      @(posedge clk);
      #1;
      if (xk >= 0) begin
         in_idx[xk]++;
         drive(xk);
      end
      cyc++;
   endtask

   task automatic test_reset();
      do_reset();
      vectors += 5;
      if (o_tval !== 1'b0) begin errors++; $display("FAIL reset_tval: got %b required 0", o_tval); end
      if (o_rrdy !== 4'b0) begin errors++; $display("FAIL reset_rrdy: got %b required 0000", o_rrdy); end
      if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h required 0", o_data); end
      if (o_src !== 3'd0) begin errors++; $display("FAIL reset_src: got %0d required 0", o_src); end
      if (o_word_cnt !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %h required 0", o_word_cnt); end
   endtask

   task automatic test_single();
      int lc;
      do_reset();
      load(0, 6);
      lc = cyc;
      for (int b = 0; b < 40 && out_src.size() < 6; b++) cycle();
      vectors++;
      if (out_src.size() != 6) begin
         errors++;
         $display("FAIL single_count: got %0d words required 6", out_src.size());
      end else begin
         vectors += 6;
         if (in_cyc[0] != lc + 1) begin errors++; $display("FAIL single_rrdy_lat: got %0d required %0d", in_cyc[0] - lc, 1); end
         if (out_cyc[0] != lc + 2) begin errors++; $display("FAIL single_tval_lat: got %0d required %0d", out_cyc[0] - lc, 2); end
         if (out_cyc[3] - out_cyc[0] != 3) begin errors++; $display("FAIL single_burst: got %0d required 3", out_cyc[3] - out_cyc[0]); end
         if (out_cyc[4] - out_cyc[3] != 2) begin errors++; $display("FAIL single_bubble: got %0d required 2", out_cyc[4] - out_cyc[3]); end
         if (out_cyc[5] - out_cyc[4] != 1) begin errors++; $display("FAIL single_tail: got %0d required 1", out_cyc[5] - out_cyc[4]); end
         if (rr_log[in_cyc[3] + 1][0] !== 1'b0) begin errors++; $display("FAIL single_idle_rrdy: got %b required 0", rr_log[in_cyc[3] + 1][0]); end
         foreach (out_src[i]) begin
            vectors++;
            if (out_src[i] != 0) begin errors++; $display("FAIL single_src %0d: got %0d required 0", i, out_src[i]); end
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int k = 0; k < 4; k++) load(k, 8);
      for (int b = 0; b < 200 && out_src.size() < 32; b++) cycle();
      vectors++;
      if (out_src.size() != 32) begin
         errors++;
         $display("FAIL contention_count: got %0d words required 32", out_src.size());
      end else begin
         foreach (out_src[i]) begin
            vectors++;
            if (out_src[i] != (i / 4) % 4) begin
               errors++;
               $display("FAIL contention_src %0d: got %0d required %0d", i, out_src[i], (i / 4) % 4);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int exp_src [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
      do_reset();
      load(0, 5);
      load(1, 5);
      for (int b = 0; b < 400 && out_src.size() < 10; b++) begin
         i_trdy = (cyc % 8) == 0;
         cycle();
      end
      i_trdy = 1'b1;
      vectors += 2;
      if (in_cyc.size() != 10) begin errors++; $display("FAIL bp_in_count: got %0d required 10", in_cyc.size()); end
      if (out_src.size() != 10) begin
         errors++;
         $display("FAIL bp_out_count: got %0d required 10", out_src.size());
      end else begin
         foreach (out_src[i]) begin
            vectors++;
            if (out_src[i] != exp_src[i]) begin
               errors++;
               $display("FAIL bp_src %0d: got %0d required %0d", i, out_src[i], exp_src[i]);
            end
         end
      end
   endtask

   task automatic test_early_release();
      int exp_src [8] = '{2, 2, 3, 3, 3, 3, 3, 3};
      do_reset();
      load(2, 2);
      load(3, 6);
      for (int b = 0; b < 40 && in_idx[3] < 1; b++) cycle();
      vectors += 2;
      if (in_idx[2] != 2) begin errors++; $display("FAIL early_words2: got %0d required 2", in_idx[2]); end
      if (dut.rr_ptr !== 3'd3) begin errors++; $display("FAIL early_rr_ptr: got %0d required 3", dut.rr_ptr); end
      for (int b = 0; b < 60 && out_src.size() < 8; b++) cycle();
      vectors++;
      if (out_src.size() != 8) begin
         errors++;
         $display("FAIL early_count: got %0d required 8", out_src.size());
      end else begin
         foreach (out_src[i]) begin
            vectors++;
            if (out_src[i] != exp_src[i]) begin
               errors++;
               $display("FAIL early_src %0d: got %0d required %0d", i, out_src[i], exp_src[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int exp_src [4] = '{0, 0, 1, 1};
      do_reset();
      load(1, 8);
      for (int b = 0; b < 20 && in_idx[1] < 2; b++) cycle();
      vectors++;
      if (o_tval !== 1'b1) begin errors++; $display("FAIL mid_pre_tval: got %b required 1", o_tval); end
      reset = 1'b1;
      i_rval = '0;
      #1;
      vectors += 2;
      if (o_tval !== 1'b0) begin errors++; $display("FAIL mid_tval: got %b required 0", o_tval); end
      if (o_rrdy !== 4'b0) begin errors++; $display("FAIL mid_rrdy: got %b required 0000", o_rrdy); end
      @(posedge clk);
      #1 reset = 1'b0;
      clear_sb();
      load(1, 2);
      load(0, 2);
      for (int b = 0; b < 40 && out_src.size() < 4; b++) cycle();
      vectors++;
      if (out_src.size() != 4) begin
         errors++;
         $display("FAIL mid_count: got %0d required 4", out_src.size());
      end else begin
         foreach (out_src[i]) begin
            vectors++;
            if (out_src[i] != exp_src[i]) begin
               errors++;
               $display("FAIL mid_src %0d: got %0d required %0d", i, out_src[i], exp_src[i]);
            end
         end
      end
   endtask

   task automatic test_stats();
      do_reset();
      load(1, 5);
      load(2, 3);
      for (int b = 0; b < 60 && out_src.size() < 8; b++) cycle();
      repeat (2) cycle();
`ifdef CONV_ARB_STATS_EN
      vectors += 3;
      if (o_word_cnt[31:16] !== 16'd5) begin errors++; $display("FAIL stats_cnt1: got %0d required 5", o_word_cnt[31:16]); end
      if (o_word_cnt[47:32] !== 16'd3) begin errors++; $display("FAIL stats_cnt2: got %0d required 3", o_word_cnt[47:32]); end
      if (o_word_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stats_cnt0: got %0d required 0", o_word_cnt[15:0]); end
`else
      vectors++;
      if (o_word_cnt !== 64'h0) begin errors++; $display("FAIL stats_off: got %h required 0", o_word_cnt); end
`endif
      i_cnt_clr = 1'b1;
      @(posedge clk);
      #1 i_cnt_clr = 1'b0;
      vectors++;
      if (o_word_cnt !== 64'h0) begin errors++; $display("FAIL stats_clr: got %h required 0", o_word_cnt); end
`ifdef CONV_ARB_STATS_EN
      clear_sb();
      load(1, 65540);
      for (int b = 0; b < 90000 && in_idx[1] < 65540; b++) cycle();
      vectors++;
      if (o_word_cnt[31:16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h required ffff", o_word_cnt[31:16]); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_early_release();
      test_reset_mid();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/convert_arb_64.md
Name: convert_arb_64

Overview:
- Round-robin arbiter that shares one 64-bit word channel (feeding the 64-to-8 byte serializer) among N requesters.
- Grants one requester at a time, for a burst of up to MAX_BURST words, then rotates.
- Registers the selected word and its source ID in a single-entry output stage with the same valid/ready handshake the serializer uses.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 64, word width.
- MAX_BURST, 4, maximum words accepted per grant (1..15).
- SW, 3, source-ID width; must satisfy 2**SW >= N.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  N*DW  requester words; requester k uses bits [k*DW +: DW].
- i_rval  input  N  per-requester valid.
- o_rrdy  output  N  per-requester ready; at most one bit is high in any cycle.
- o_data  output  DW  registered word to the serializer.
- o_src  output  SW  index of the requester that supplied o_data.
- o_tval  output  1  o_data/o_src valid.
- i_trdy  input  1  serializer ready.
- i_cnt_clr  input  1  synchronous clear of the statistics counters (optional feature).
- o_word_cnt  output  N*16  per-requester accepted-word counters (optional feature).

Behaviour:
- Reset values: state IDLE, rr_ptr 0, burst_cnt 0, o_tval 0, o_data 0, o_src 0, o_rrdy 0, o_word_cnt 0.
- out_rdy = ~o_tval | i_trdy (combinational). An output transfer occurs when o_tval & i_trdy; an input transfer from requester k occurs when i_rval[k] & o_rrdy[k].
- IDLE:
  - o_rrdy = 0.
  - If any i_rval bit is set, owner = first set index scanning rr_ptr, rr_ptr+1, ... modulo N.
  - Go to GRANT with burst_cnt = 0.
  - If no i_rval bit is set, stay in IDLE.
- GRANT:
  - o_rrdy[owner] = out_rdy; all other bits are 0.
  - On an input transfer: o_data <= owner's word, o_src <= owner, o_tval <= 1, burst_cnt++.
  - If burst_cnt reaches MAX_BURST, or i_rval[owner] is 0 in a cycle: release. Release sets rr_ptr <= (owner+1) mod N and returns to IDLE.
  - An input transfer and a release may occur in the same cycle.
- Output stage:
  - If an output transfer occurs with no input transfer in the same cycle, o_tval <= 0.
  - If an input and an output transfer occur in the same cycle, the register reloads with no bubble and o_tval stays 1.
  - o_data and o_src are held stable while o_tval=1 and i_trdy=0.
- Latency: i_rval rising in IDLE → o_rrdy high 1 cycle later → o_tval high 2 cycles after i_rval.
- Steady state is one word per cycle while i_trdy=1. Each grant costs one IDLE bubble cycle.
- A requester's i_rval dropping mid-burst ends the burst; the grant is not held open.
- An owner word is never dropped or duplicated. A word is accepted only on an input transfer.
- Reset mid-operation: the word held in the output register is discarded and rr_ptr returns to 0.
- With MAX_BURST=1, grants strictly alternate among active requesters.

Optional Feature:
- Macro: CONV_ARB_STATS_EN.
- Defined:
  - o_word_cnt[k*16 +: 16] increments on each input transfer from requester k and saturates at 16'hFFFF.
  - i_cnt_clr=1 clears all counters, taking priority over a same-cycle increment.
- Undefined:
  - o_word_cnt is tied to 0 and i_cnt_clr is ignored.
  - Port list is unchanged.

Test Plan:
- Single requester: i_rval=4'b0001 with 6 words, i_trdy=1 → words appear on o_data in order with o_src=0. Words 1-4 are consecutive, then one idle cycle, then words 5-6. o_rrdy[0]=0 during the IDLE cycle.
- Contention: i_rval=4'b1111 held high, MAX_BURST=4 → o_src sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. At most one o_rrdy bit is ever high.
- Backpressure: i_trdy toggled as 1 high / 7 low (serializer pattern) → o_data and o_src are stable while i_trdy=0, and no word is lost. The word count at the output equals the word count at the input.
- Early release: requester 2 drops i_rval after 2 words while requester 3 is valid → the next grant goes to requester 3 and rr_ptr=3.
- Reset while o_tval=1 and burst_cnt=2 → o_tval=0, o_rrdy=0, and the next grant starts from requester 0.
- With CONV_ARB_STATS_EN: 70000 words from requester 1 → o_word_cnt[31:16]=16'hFFFF. Pulsing i_cnt_clr → all counters are 0 the next cycle.
